conv_pad_feeder: RTL
====================

# conv_pad_feeder

Source-side streamer for the RGB convolution stage. Takes an unpadded W×H RGB pixel stream from the frame reader through a valid/ready handshake, adds a one-pixel zero border, and drives the padded S×S stream (S = W+2) into the convolution input port. It also carries a per-pass repeat flag, so the same frame can be replayed once per filter pass.

## Interface
Parameters:
- M, 8, pixel channel width
- W, 480, active frame width in pixels
- H, 480, active frame height in pixels
- S, W+2, padded line length; derived, never overridden

Ports:
- clk  in  1  system clock; all logic on rising edge
- Rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame pass; honoured only in IDLE
- repeat_req  in  1  sampled with start; marks the pass as a replay
- din_r, din_g, din_b  in  M each  upstream pixel channels
- din_valid  in  1  upstream pixel present
- din_ready  out  1  block accepts the upstream pixel this cycle
- dout_r, dout_g, dout_b  out  M each  padded pixel to the convolution stage
- valid_out  out  1  dout_* valid this cycle
- repeat_out  out  1  latched repeat_req; held for the whole pass
- busy  out  1  pass in progress (state ≠ IDLE)
- frame_done  out  1  one-cycle pulse coincident with the last padded pixel

## Operation
- Position counters: col in 0..S-1, row in 0..S-1. The pair advances only when a padded pixel is emitted. col wraps S-1→0 and increments row.
- Border position: row==0, row==S-1, col==0 or col==S-1. Emits 0 on all channels without waiting for upstream; din_ready=0.
- Interior position: din_ready=1. When din_valid&&din_ready, the pixel is registered to dout_* with valid_out=1 and the counters advance. When din_valid=0, the block stalls: valid_out=0 and the counters hold.
- FSM states:
  - IDLE: on start, latch repeat_req, clear counters, go to RUN. Other inputs ignored.
  - RUN: emits positions as above. After emitting (S-1,S-1), go to IDLE and pulse frame_done.
  - GAP: present only under the configuration macro; see below.
- start during RUN or GAP is ignored. repeat_req is only sampled with an honoured start.
- din_ready is combinational from state and position only, never from din_valid.
- Upstream must supply exactly W×H pixels per pass. Surplus pixels are never accepted (din_ready=0 in IDLE).
- Reset mid-pass: counters and state clear immediately. No frame_done is emitted. The partial pass is abandoned.

## Timing
- Reset values: dout_*=0, valid_out=0, repeat_out=0, busy=0, frame_done=0, din_ready=0.
- First output: start at cycle t gives the (0,0) border pixel at cycle t+2 (t+1 enters RUN, output registered).
- Accepted upstream pixel appears on dout_* exactly one cycle after the handshake.
- Unstalled pass: S×S consecutive valid_out cycles (S=482: 232324 cycles).
- frame_done is high in the same cycle as the last valid_out. busy drops the cycle after.
- A start arriving the cycle busy falls is accepted, so back-to-back passes are separated by one idle cycle.

## Configuration
- CONV_PAD_LINE_GAP_EN defined:
  - After each col S-1 emission, except on the final row, enter GAP for one cycle (valid_out=0, din_ready=0), then return to RUN.
  - An unstalled pass takes S×S+(S-1) cycles.
  - The gap gives downstream line buffers a row turnaround cycle.
- Undefined: no GAP state; rows are emitted back-to-back.

## Structure
- Shared package conv_pkg:
  - FSM state enum (IDLE, RUN, GAP)
  - PAD_VAL constant (0)
  - padded-size helper constant derived from W
- Sub-module conv_pos_cnt:
  - holds the col/row counters with advance enable, wrap and last-position flag
  - reusable by the output collector on the convolution's far side

## Test plan
- W=H=4 (S=6), continuous din_valid, start pulse: 36 valid_out cycles; 16 handshakes; border pixels all zero; pixel k of the input appears at row 1+k/4, col 1+k%4; frame_done on output 36.
- Same config, din_valid low for 3 cycles on the third interior pixel: valid_out gap of 3 cycles; no border pixel emitted during the stall; output order unchanged; total 36 outputs.
- start with repeat_req=1, then repeat_req toggled mid-pass: repeat_out stays 1 all pass; returns to 0 only when the next start samples repeat_req=0.
- start pulsed again at output 10: ignored; exactly 36 outputs and one frame_done.
- Rst asserted at output 20: all outputs 0 the same cycle; busy=0; no frame_done; the next start produces a full 36-output pass from (0,0).
- With CONV_PAD_LINE_GAP_EN, S=6: exactly 5 single-cycle gaps, each following col 5 of rows 0..4; pass completes in 41 cycles.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the RGB convolution stage.
package conv_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StGap} conv_state_e;

  localparam int unsigned PAD_VAL = 0;

  // One zero pixel on each side of the active line.
  function automatic int unsigned padded_size(input int unsigned w);
    return w + 2;
  endfunction

endpackage

// File: rtl/conv_pad_feeder_if.sv
// Pass control and pixel streams between frame reader, padder and convolution input.
interface conv_pad_feeder_if #(
  parameter int unsigned M = 8
);
  logic         start;
  logic         repeat_req;
  logic [M-1:0] din_r;
  logic [M-1:0] din_g;
  logic [M-1:0] din_b;
  logic         din_valid;
  logic         din_ready;
  logic [M-1:0] dout_r;
  logic [M-1:0] dout_g;
  logic [M-1:0] dout_b;
  logic         valid_out;
  logic         repeat_out;
  logic         busy;
  logic         frame_done;

  modport master (
    output start, repeat_req, din_r, din_g, din_b, din_valid,
    input  din_ready, dout_r, dout_g, dout_b, valid_out, repeat_out, busy, frame_done
  );

  modport slave (
    input  start, repeat_req, din_r, din_g, din_b, din_valid,
    output din_ready, dout_r, dout_g, dout_b, valid_out, repeat_out, busy, frame_done
  );

endinterface

// File: rtl/conv_pos_cnt.sv
// Column/row position counter over a padded frame, with wrap and last-position flags.
module conv_pos_cnt #(
  parameter int unsigned Cols = 6,
  parameter int unsigned Rows = 6,
  parameter int unsigned CW   = $clog2(Cols),
  parameter int unsigned RW   = $clog2(Rows)
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          col_last,
  output logic          row_last
);

  assign col_last = (col == CW'(Cols - 1));
  assign row_last = (row == RW'(Rows - 1));

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_pad_feeder.sv
// Zero-border padder feeding the convolution input. Defining CONV_PAD_LINE_GAP_EN inserts
// one idle cycle after every padded row except the last.
module conv_pad_feeder
  import conv_pkg::*;
#(
  parameter int unsigned M = 8,
  parameter int unsigned W = 480,
  parameter int unsigned H = 480
) (
  input logic              clk,
  input logic              Rst,
  conv_pad_feeder_if.slave bus
);

  localparam int unsigned S  = padded_size(W);
  localparam int unsigned SR = padded_size(H);

  conv_state_e            state;
  logic [$clog2(S)-1:0]   col;
  logic [$clog2(SR)-1:0]  row;
  logic                   col_last;
  logic                   row_last;
  logic                   border;
  logic                   last;
  logic                   cnt_clr;
  logic                   emit;

  assign border  = (col == '0) || col_last || (row == '0) || row_last;
  assign last    = col_last && row_last;
  assign cnt_clr = (state == StIdle) && bus.start;

  // Border positions never wait on upstream; interior positions wait for din_valid.
  assign bus.din_ready = (state == StRun) && !border;
  assign emit          = (state == StRun) && (border || bus.din_valid);

  conv_pos_cnt #(
    .Cols(S),
    .Rows(SR)
  ) u_pos_cnt (
    .clk     (clk),
    .Rst     (Rst),
    .clr     (cnt_clr),
    .adv     (emit),
    .col     (col),
    .row     (row),
    .col_last(col_last),
    .row_last(row_last)
  );

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state          <= StIdle;
      bus.dout_r     <= '0;
      bus.dout_g     <= '0;
      bus.dout_b     <= '0;
      bus.valid_out  <= 1'b0;
      bus.repeat_out <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.valid_out  <= 1'b0;
      bus.frame_done <= 1'b0;
      // busy trails the FSM so it covers the final output cycle.
      if (bus.frame_done) bus.busy <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            state          <= StRun;
            bus.repeat_out <= bus.repeat_req;
            bus.busy       <= 1'b1;
          end
        end
        StRun: begin
          if (emit) begin
            bus.valid_out <= 1'b1;
            bus.dout_r    <= border ? M'(PAD_VAL) : bus.din_r;
            bus.dout_g    <= border ? M'(PAD_VAL) : bus.din_g;
            bus.dout_b    <= border ? M'(PAD_VAL) : bus.din_b;
            if (last) begin
              state          <= StIdle;
              bus.frame_done <= 1'b1;
            end
`ifdef CONV_PAD_LINE_GAP_EN
            else if (col_last) begin
              state <= StGap;
            end
`endif
          end
        end
`ifdef CONV_PAD_LINE_GAP_EN
        StGap: state <= StRun;
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule
